rle_stream: RTL and testbench

RLE_STREAM -- requirements
Module: rle_stream

---
 rtl/rle_pkg.sv | 18 +
 rtl/rle_pack.sv | 56 +++++
 rtl/rle_stream.sv | 271 +++++++++++++++++++++++++++
 tb/tb_rle_stream.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rle_pkg.sv
// Shared types and constants for the RLE stream compressor.
package rle_pkg;

    localparam int PAIR_BYTES = 2;
    localparam int WORD_W     = 32;
    localparam int WORD_BYTES = WORD_W / 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        SCAN    = 3'd3,
        WR      = 3'd4,
        FLUSH   = 3'd5,
        DONE    = 3'd6
    } state_t;

endpackage

// File: rtl/rle_pack.sv
// Packs 2-byte {count, symbol} pairs little-endian into 32-bit output words.
// Unfilled upper lanes stay zero, so a half word can be written as it stands.
module rle_pack
    import rle_pkg::*;
(
    input  logic                    clk,
    input  logic                    nreset,
    input  logic                    i_clear,
    input  logic                    i_push,
    input  logic [PAIR_BYTES*8-1:0] i_pair,
    input  logic                    i_drain,
    output logic [WORD_W-1:0]       o_word_next,
    output logic                    o_full_next,
    output logic                    o_empty
);

    logic [WORD_W-1:0] r_word;
    logic [2:0]        r_lane;
    logic [WORD_W-1:0] w_word_d;
    logic [2:0]        w_lane_d;

    // Next word and byte lane: clear/drain empty the word, a push fills the lane at r_lane
    always_comb begin
        w_word_d = r_word;
        w_lane_d = r_lane;
        if (i_clear || i_drain) begin
            w_word_d = {WORD_W{1'b0}};
            w_lane_d = 3'd0;
        end else if (i_push) begin
            case (r_lane)
                3'd0:    w_word_d[15:0]  = i_pair;
                3'd2:    w_word_d[31:16] = i_pair;
                default: w_word_d        = r_word;
            endcase
            w_lane_d = r_lane + 3'(PAIR_BYTES);
        end else begin
            w_lane_d = r_lane;
        end
    end

    // Packing register
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_word <= {WORD_W{1'b0}};
            r_lane <= 3'd0;
        end else begin
            r_word <= w_word_d;
            r_lane <= w_lane_d;
        end
    end

    assign o_word_next = w_word_d;
    assign o_full_next = (w_lane_d == 3'(WORD_BYTES));
    assign o_empty     = (r_lane == 3'd0);

endmodule

// File: rtl/rle_stream.sv
// Run-length compressor: reads bytes from a dpsram, writes {count, symbol} pairs back.
// Define RLE_ABORT_EN to add the abort input.
module rle_stream
    import rle_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int MAX_RUN = 255
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              start,
`ifdef RLE_ABORT_EN
    input  logic              abort,
`endif
    input  logic [31:0]       message_addr,
    input  logic [31:0]       message_size,
    input  logic [31:0]       rle_addr,
    output logic [31:0]       rle_size,
    output logic              done,
    output logic              port_A_clk,
    output logic              port_A_we,
    output logic [ADDR_W-1:0] port_A_addr,
    output logic [31:0]       port_A_data_in,
    input  logic [31:0]       port_A_data_out
);

    state_t              r_state;
    state_t              w_state_d;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [31:0]         r_remaining;
    logic [31:0]         r_in_word;
    logic [2:0]          r_in_lane;
    logic [7:0]          r_run_sym;
    logic [7:0]          r_run_cnt;
    logic                r_run_valid;
    logic [31:0]         r_pair_cnt;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_data;
    logic                r_done;
    logic [31:0]         r_size;
    logic                w_we_d;
    logic [ADDR_W-1:0]   w_addr_d;
    logic [31:0]         w_data_d;
    logic                w_done_d;
    logic [31:0]         w_size_d;
    logic                w_start_ok;
    logic [7:0]          w_byte;
    logic                w_have_byte;
    logic                w_consume;
    logic                w_final;
    logic                w_extend;
    logic                w_push;
    logic                w_wr_fire;
    logic [31:0]         w_done_size;
    logic [WORD_W-1:0]   w_pack_word;
    logic                w_pack_full;
    logic                w_pack_empty;

    generate
        if (ADDR_W < 32) begin : g_hi_addr
            logic w_unused_hi;
            assign w_unused_hi = ^{message_addr[31:ADDR_W], rle_addr[31:ADDR_W]};
        end
    endgenerate

    assign w_start_ok  = ((r_state == IDLE) || (r_state == DONE)) && start;
    assign w_have_byte = (r_remaining != 32'd0);
    assign w_consume   = (r_state == SCAN) && w_have_byte;
    assign w_final     = (r_state == SCAN) && !w_have_byte;
    // A run keeps growing only on the same symbol and while below the count ceiling
    assign w_extend    = r_run_valid && (w_byte == r_run_sym) && (r_run_cnt != 8'(MAX_RUN));
    assign w_push      = r_run_valid && ((w_consume && !w_extend) || w_final);

`ifdef RLE_ABORT_EN
    logic        w_abort_hit;
    logic [31:0] r_word_cnt;
    assign w_abort_hit = abort && (r_state != IDLE) && (r_state != DONE);
    assign w_wr_fire   = r_we && !abort;
    assign w_done_size = w_abort_hit ? (r_word_cnt << 2'd2) : (r_pair_cnt << 2'd1);
    assign port_A_we   = r_we && !abort;

    // Words actually committed, reported as the size of an aborted job
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_word_cnt <= 32'd0;
        end else if (w_start_ok) begin
            r_word_cnt <= 32'd0;
        end else if (w_wr_fire) begin
            r_word_cnt <= r_word_cnt + 32'd1;
        end
    end
`else
    assign w_wr_fire   = r_we;
    assign w_done_size = r_pair_cnt << 2'd1;
    assign port_A_we   = r_we;
`endif

    assign port_A_clk     = clk;
    assign port_A_addr    = r_addr;
    assign port_A_data_in = r_data;
    assign done           = r_done;
    assign rle_size       = r_size;

    // Current source byte, little-endian lane order
    always_comb begin
        case (r_in_lane[1:0])
            2'd0:    w_byte = r_in_word[7:0];
            2'd1:    w_byte = r_in_word[15:8];
            2'd2:    w_byte = r_in_word[23:16];
            default: w_byte = r_in_word[31:24];
        endcase
    end

    rle_pack u_pack (
        .clk         (clk),
        .nreset      (nreset),
        .i_clear     (w_start_ok),
        .i_push      (w_push),
        .i_pair      ({r_run_sym, r_run_cnt}),
        .i_drain     ((r_state == WR) || (r_state == FLUSH)),
        .o_word_next (w_pack_word),
        .o_full_next (w_pack_full),
        .o_empty     (w_pack_empty)
    );

    // FSM state register
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_d = (message_size == 32'd0) ? DONE : RD_REQ;
                end else begin
                    w_state_d = r_state;
                end
            end
            RD_REQ:  w_state_d = RD_WAIT;
            RD_WAIT: w_state_d = SCAN;
            SCAN: begin
                if (!w_have_byte) begin
                    w_state_d = FLUSH;
                end else if (w_pack_full) begin
                    w_state_d = WR;
                end else if ((r_in_lane == 3'd3) && (r_remaining != 32'd1)) begin
                    w_state_d = RD_REQ;
                end else begin
                    w_state_d = SCAN;
                end
            end
            WR: begin
                if ((r_in_lane == 3'(WORD_BYTES)) && w_have_byte) begin
                    w_state_d = RD_REQ;
                end else begin
                    w_state_d = SCAN;
                end
            end
            FLUSH:   w_state_d = DONE;
            default: w_state_d = IDLE;
        endcase
`ifdef RLE_ABORT_EN
        if (w_abort_hit) begin
            w_state_d = DONE;
        end else begin
            w_state_d = w_state_d;
        end
`endif
    end

    // FSM output logic: next values of the registered memory port and status outputs
    always_comb begin
        w_we_d   = 1'b0;
        w_addr_d = r_addr;
        w_data_d = r_data;
        w_done_d = r_done;
        w_size_d = r_size;
        if (w_start_ok) begin
            w_done_d = (message_size == 32'd0);
            w_size_d = 32'd0;
            if (message_size != 32'd0) begin
                w_addr_d = message_addr[ADDR_W-1:0];
            end else begin
                w_addr_d = r_addr;
            end
        end else if ((w_state_d == DONE) && (r_state != DONE)) begin
            w_done_d = 1'b1;
            w_size_d = w_done_size;
        end else if (w_state_d == RD_REQ) begin
            w_addr_d = r_rd_addr;
        end else if ((w_state_d == WR) ||
                     ((w_state_d == FLUSH) && (w_push || !w_pack_empty))) begin
            w_we_d   = 1'b1;
            w_addr_d = r_wr_addr;
            w_data_d = w_pack_word;
        end else begin
            w_we_d = 1'b0;
        end
    end

    // Registered memory port and status outputs
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_we   <= 1'b0;
            r_addr <= {ADDR_W{1'b0}};
            r_data <= 32'd0;
            r_done <= 1'b0;
            r_size <= 32'd0;
        end else begin
            r_we   <= w_we_d;
            r_addr <= w_addr_d;
            r_data <= w_data_d;
            r_done <= w_done_d;
            r_size <= w_size_d;
        end
    end

    // Source/destination pointers and run detector
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_rd_addr   <= {ADDR_W{1'b0}};
            r_wr_addr   <= {ADDR_W{1'b0}};
            r_remaining <= 32'd0;
            r_in_word   <= 32'd0;
            r_in_lane   <= 3'd0;
            r_run_sym   <= 8'd0;
            r_run_cnt   <= 8'd0;
            r_run_valid <= 1'b0;
            r_pair_cnt  <= 32'd0;
        end else if (w_start_ok) begin
            r_rd_addr   <= message_addr[ADDR_W-1:0];
            r_wr_addr   <= rle_addr[ADDR_W-1:0];
            r_remaining <= message_size;
            r_in_lane   <= 3'd0;
            r_run_cnt   <= 8'd0;
            r_run_valid <= 1'b0;
            r_pair_cnt  <= 32'd0;
        end else begin
            if (r_state == RD_WAIT) begin
                r_in_word <= port_A_data_out;
                r_in_lane <= 3'd0;
                r_rd_addr <= r_rd_addr + ADDR_W'(3'd4);
            end
            if (w_consume) begin
                r_remaining <= r_remaining - 32'd1;
                r_in_lane   <= r_in_lane + 3'd1;
                r_run_sym   <= w_byte;
                r_run_cnt   <= w_extend ? (r_run_cnt + 8'd1) : 8'd1;
                r_run_valid <= 1'b1;
            end else if (w_final) begin
                r_run_valid <= 1'b0;
            end
            if (w_push) begin
                r_pair_cnt <= r_pair_cnt + 32'd1;
            end
            if (w_wr_fire) begin
                r_wr_addr <= r_wr_addr + ADDR_W'(3'd4);
            end
        end
    end

endmodule

// File: tb/tb_rle_stream.sv
// Self-checking bench for rle_stream: a queue-based RLE model predicts every written word.
`timescale 1ns/1ps
module tb_rle_stream;

    localparam int ADDR_W  = 16;
    localparam int MAX_RUN = 255;

    logic              clk = 1'b0;
    logic              nreset = 1'b0;
    logic              start = 1'b0;
    logic [31:0]       message_addr = 32'd0;
    logic [31:0]       message_size = 32'd0;
    logic [31:0]       rle_addr = 32'd0;
    logic [31:0]       rle_size;
    logic              done;
    logic              port_A_clk;
    logic              port_A_we;
    logic [ADDR_W-1:0] port_A_addr;
    logic [31:0]       port_A_data_in;
    logic [31:0]       port_A_data_out;
`ifdef RLE_ABORT_EN
    logic              abort = 1'b0;
`endif

    always #5 clk = ~clk;

    rle_stream #(.ADDR_W(ADDR_W), .MAX_RUN(MAX_RUN)) dut (
        .clk             (clk),
        .nreset          (nreset),
        .start           (start),
`ifdef RLE_ABORT_EN
        .abort           (abort),
`endif
        .message_addr    (message_addr),
        .message_size    (message_size),
        .rle_addr        (rle_addr),
        .rle_size        (rle_size),
        .done            (done),
        .port_A_clk      (port_A_clk),
        .port_A_we       (port_A_we),
        .port_A_addr     (port_A_addr),
        .port_A_data_in  (port_A_data_in),
        .port_A_data_out (port_A_data_out)
    );

    // Synchronous-read source memory (4 KB mirror of the address space)
    logic [31:0] mem [0:1023];
    logic [31:0] rdata;
    always @(posedge clk) rdata <= mem[port_A_addr[11:2]];
    assign port_A_data_out = rdata;

    int                errors = 0;
    int                checks = 0;
    logic [7:0]        msg_q[$];
    logic [31:0]       exp_q[$];
    int                exp_size = 0;
    int                n_exp = 0;
    int                wr_seen = 0;
    bit                chk_en = 1'b0;
    logic [ADDR_W-1:0] exp_wr_addr = '0;
    logic [7:0]        mix_tab [0:23];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // RLE model: split message into runs capped at MAX_RUN, lay out count/symbol bytes, chop into words
    task automatic build_model(input logic [ADDR_W-1:0] dst);
        logic [7:0]  out_b[$];
        logic [31:0] w;
        int i;
        int j;
        exp_q.delete();
        i = 0;
        while (i < msg_q.size()) begin
            j = i;
            while (j < msg_q.size() && msg_q[j] == msg_q[i] && (j - i) < MAX_RUN) j++;
            out_b.push_back(8'(j - i));
            out_b.push_back(msg_q[i]);
            i = j;
        end
        exp_size = out_b.size();
        for (int k = 0; k < out_b.size(); k += 4) begin
            w = 32'd0;
            for (int m = 0; m < 4; m++)
                if (k + m < out_b.size()) w[8*m +: 8] = out_b[k+m];
            exp_q.push_back(w);
        end
        n_exp = exp_q.size();
        exp_wr_addr = dst;
    endtask

    // Little-endian load; bytes past the message are filler the DUT must ignore
    task automatic load_mem(input logic [31:0] base);
        logic [31:0]       word;
        logic [ADDR_W-1:0] a;
        for (int w = 0; w < (msg_q.size() + 3) / 4; w++) begin
            word = 32'hEEEE_EEEE;
            for (int m = 0; m < 4; m++)
                if (4*w + m < msg_q.size()) word[8*m +: 8] = msg_q[4*w + m];
            a = ADDR_W'(base + 32'(4*w));
            mem[a[11:2]] = word;
        end
    endtask

    task automatic fill_const(input int n, input logic [7:0] v);
        msg_q.delete();
        for (int i = 0; i < n; i++) msg_q.push_back(v);
    endtask

    // Compare every write against the model
    always @(negedge clk) begin
        if (nreset && port_A_we) begin
            wr_seen++;
            if (chk_en) begin
                if (exp_q.size() == 0) begin
                    check("extra_write", 32'(wr_seen), 32'(n_exp));
                end else begin
                    check("wr_addr", 32'(port_A_addr), 32'(exp_wr_addr));
                    check("wr_data", port_A_data_in, exp_q.pop_front());
                    exp_wr_addr = exp_wr_addr + ADDR_W'(4);
                end
            end
        end
    end

    task automatic kick(input logic [31:0] src, input logic [31:0] dst);
        @(negedge clk);
        wr_seen      = 0;
        message_addr = src;
        message_size = 32'(msg_q.size());
        rle_addr     = dst;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
    endtask

    task automatic run_job(input string name, input logic [31:0] src, input logic [31:0] dst, input bit poke);
        int cyc;
        load_mem(src);
        build_model(ADDR_W'(dst));
        chk_en = 1'b1;
        kick(src, dst);
        check({name, "_done_drop"}, 32'(done), 32'd0);
        check({name, "_size_clear"}, rle_size, 32'd0);
        cyc = 0;
        while (!done && cyc < 5000) begin
            if (poke && cyc == 5) begin
                start = 1'b1; message_addr = 32'h0000_0F00; rle_addr = 32'h0000_0FF0; message_size = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({name, "_done"}, 32'(done), 32'd1);
        check({name, "_rle_size"}, rle_size, 32'(exp_size));
        check({name, "_writes"}, 32'(wr_seen), 32'(n_exp));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        mix_tab = '{8'hAA, 8'hBB, 8'hBB, 8'hBB, 8'hAA, 8'hAA, 8'h00, 8'hFF,
                    8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h11, 8'h12,
                    8'h12, 8'h12, 8'h12, 8'h12, 8'h33, 8'h33, 8'h33, 8'h33};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_done", 32'(done), 32'd0);
        check("rst_size", rle_size, 32'd0);
        check("rst_we", 32'(port_A_we), 32'd0);
        check("rst_addr", 32'(port_A_addr), 32'd0);
        check("rst_data", port_A_data_in, 32'd0);
        nreset = 1'b1;
        repeat (2) @(negedge clk);

        // Empty message: done one cycle after start, no traffic
        msg_q.delete();
        chk_en = 1'b0;
        kick(32'h0000_0040, 32'h0000_0100);
        check("empty_done", 32'(done), 32'd1);
        check("empty_size", rle_size, 32'd0);
        repeat (4) @(negedge clk);
        check("empty_writes", 32'(wr_seen), 32'd0);

        // Two runs across two words
        msg_q = '{8'h41, 8'h41, 8'h41, 8'h41, 8'h41, 8'h41, 8'h42, 8'h42};
        build_model(ADDR_W'(32'h0100));
        check("model_A_words", 32'(n_exp), 32'd1);
        check("model_A_word0", exp_q[0], 32'h4202_4106);
        run_job("A", 32'h0000_0000, 32'h0000_0100, 1'b0);
        check("A_mem_word1", mem[1], 32'h4242_4141);

        // 300 equal bytes split at the run ceiling: 255 then 45, count in byte 0
        fill_const(300, 8'h00);
        build_model(ADDR_W'(32'h0100));
        check("model_B_word0", exp_q[0], 32'h002D_00FF);
        run_job("B", 32'h0000_0400, 32'h0000_0100, 1'b0);

        // Exactly one byte over the ceiling
        fill_const(256, 8'h5A);
        run_job("B256", 32'h0000_0400, 32'h0000_0180, 1'b0);

        // All runs of one, half word at the end
        msg_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        build_model(ADDR_W'(32'h0120));
        check("model_C_last", exp_q[2], 32'h0000_0501);
        check("model_C_size", 32'(exp_size), 32'd10);
        run_job("C", 32'h0000_0800, 32'h0000_0120, 1'b0);

        // Mixed runs, with a start pulse while busy that must be ignored
        msg_q.delete();
        for (int i = 0; i < 24; i++) msg_q.push_back(mix_tab[i]);
        run_job("MIX", 32'h0000_0C00, 32'h0000_0300, 1'b1);

        // Source and destination wrapping past the top of the address space
        msg_q = '{8'h07, 8'h07, 8'h07, 8'h09, 8'h09, 8'h09, 8'h09, 8'h09, 8'h03, 8'h03, 8'h01, 8'h01};
        build_model(ADDR_W'(32'h0002_FFFC));
        check("model_W_word1", exp_q[1], 32'h0102_0302);
        run_job("WRAP", 32'h0001_FFF8, 32'h0002_FFFC, 1'b0);

        // Reset in the middle of a long scan
        fill_const(300, 8'h77);
        load_mem(32'h0000_0400);
        chk_en = 1'b0;
        kick(32'h0000_0400, 32'h0000_0200);
        repeat (20) @(negedge clk);
        #2 nreset = 1'b0;
        #1;
        check("midrst_we", 32'(port_A_we), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_addr", 32'(port_A_addr), 32'd0);
        check("midrst_writes", 32'(wr_seen), 32'd0);
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_idle_we", 32'(wr_seen), 32'd0);
        msg_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        run_job("C_after_rst", 32'h0000_0800, 32'h0000_0120, 1'b0);

`ifdef RLE_ABORT_EN
        // Abort once the first word has been written
        begin
            int cyc;
            msg_q.delete();
            for (int i = 0; i < 20; i++) msg_q.push_back(8'(i + 1));
            load_mem(32'h0000_0800);
            build_model(ADDR_W'(32'h0140));
            chk_en = 1'b1;
            kick(32'h0000_0800, 32'h0000_0140);
            cyc = 0;
            while (!port_A_we && cyc < 200) begin
                @(negedge clk);
                cyc++;
            end
            check("abort_first_we", 32'(port_A_we), 32'd1);
            @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            check("abort_done", 32'(done), 32'd1);
            check("abort_size", rle_size, 32'd4);
            repeat (20) @(negedge clk);
            check("abort_writes", 32'(wr_seen), 32'd1);
            chk_en = 1'b0;
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
